// File: rtl/c_seq_gen_stream.sv
// Gold-sequence generator: x1/x2 LFSR pair with NC-bit warm-up discard, emitting
// NGEN_BIT-bit words under valid/ready for a programmed number of words.
module c_seq_gen_stream #(
  parameter int unsigned NGEN_BIT = 8,
  parameter int unsigned NC       = 1600,
  parameter int unsigned LEN_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [30:0]         i_init,
  input  logic [LEN_W-1:0]    i_len,
  input  logic                i_ready,
  output logic [NGEN_BIT-1:0] o_seq_bit,
  output logic                o_valid,
  output logic                o_last,
  output logic                o_busy
);

  localparam int unsigned WU_CYC = NC / NGEN_BIT;
  localparam int unsigned WU_W   = (WU_CYC > 1) ? $clog2(WU_CYC) : 1;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t            state, state_nxt;
  logic [30:0]       x1, x2, x1_nxt, x2_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [WU_W-1:0]   wu_cnt, wu_nxt;
  logic              load_ok;

  // NGEN_BIT unrolled steps of x1(n+31) = x1(n+3) ^ x1(n)
  function automatic logic [30:0] adv_x1(input logic [30:0] s);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < int'(NGEN_BIT); i++) t = {t[3] ^ t[0], t[30:1]};
    return t;
  endfunction

  // NGEN_BIT unrolled steps of x2(n+31) = x2(n+3) ^ x2(n+2) ^ x2(n+1) ^ x2(n)
  function automatic logic [30:0] adv_x2(input logic [30:0] s);
    logic [30:0] t;
    t = s;
    for (int i = 0; i < int'(NGEN_BIT); i++) t = {t[3] ^ t[2] ^ t[1] ^ t[0], t[30:1]};
    return t;
  endfunction

  assign load_ok = i_load && (i_len != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      x1     <= '0;
      x2     <= '0;
      cnt    <= '0;
      wu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      x1     <= x1_nxt;
      x2     <= x2_nxt;
      cnt    <= cnt_nxt;
      wu_cnt <= wu_nxt;
    end
  end

  // A valid load restarts from any state, overriding a same-cycle handshake
  always_comb begin
    state_nxt = state;
    x1_nxt    = x1;
    x2_nxt    = x2;
    cnt_nxt   = cnt;
    wu_nxt    = wu_cnt;
    if (load_ok) begin
      x1_nxt    = 31'h1;
      x2_nxt    = i_init;
      cnt_nxt   = i_len;
      wu_nxt    = '0;
      state_nxt = (NC > 0) ? WARMUP : RUN;
    end else begin
      case (state)
        WARMUP: begin
          x1_nxt = adv_x1(x1);
          x2_nxt = adv_x2(x2);
          if (wu_cnt == WU_W'(WU_CYC - 1)) state_nxt = RUN;
          else                             wu_nxt    = wu_cnt + WU_W'(1);
        end
        RUN: begin
          if (i_ready) begin
            x1_nxt  = adv_x1(x1);
            x2_nxt  = adv_x2(x2);
            cnt_nxt = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_seq_bit = x1[NGEN_BIT-1:0] ^ x2[NGEN_BIT-1:0];
  assign o_valid   = (state == RUN);
  assign o_last    = (state == RUN) && (cnt == LEN_W'(1));
  assign o_busy    = (state != IDLE);

endmodule

// File: tb/tb_c_seq_gen_stream.sv
// Scoreboard bench for c_seq_gen_stream: default instance plus an NC=0 instance.
module tb_c_seq_gen_stream;

  localparam int unsigned NB  = 8;
  localparam int unsigned NCD = 1600;
  localparam int unsigned LW  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          i_load, i_ready;
  logic [30:0]   i_init;
  logic [LW-1:0] i_len;
  logic [NB-1:0] o_seq_bit;
  logic          o_valid, o_last, o_busy;

  logic          ld0, rdy0;
  logic [30:0]   init0;
  logic [LW-1:0] len0;
  logic [NB-1:0] seq0;
  logic          v0, l0, b0;

  c_seq_gen_stream #(.NGEN_BIT(NB), .NC(NCD), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_init(i_init), .i_len(i_len),
    .i_ready(i_ready), .o_seq_bit(o_seq_bit), .o_valid(o_valid),
    .o_last(o_last), .o_busy(o_busy)
  );

  c_seq_gen_stream #(.NGEN_BIT(NB), .NC(0), .LEN_W(LW)) dut0 (
    .clk(clk), .rst(rst), .i_load(ld0), .i_init(init0), .i_len(len0),
    .i_ready(rdy0), .o_seq_bit(seq0), .o_valid(v0),
    .o_last(l0), .o_busy(b0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [NB-1:0] exp_q[$];
  logic          exp_l_q[$];
  logic [NB-1:0] obs_q[$];
  logic          obs_l_q[$];
  int first_k, inj_first_k, stab_err, hs_cnt;
  bit timeout;

  // Bit-serial reference: build x1/x2 sequences, discard nc bits, pack words
  task automatic push_model(input logic [30:0] init, input int len, input int nc);
    bit x1[0:4095];
    bit x2[0:4095];
    logic [NB-1:0] w;
    int total;
    total = nc + len * int'(NB);
    for (int j = 0; j < 31; j++) begin
      x1[j] = (j == 0);
      x2[j] = init[j];
    end
    for (int n = 0; n < total; n++) begin
      x1[n+31] = x1[n+3] ^ x1[n];
      x2[n+31] = x2[n+3] ^ x2[n+2] ^ x2[n+1] ^ x2[n];
    end
    for (int wi = 0; wi < len; wi++) begin
      for (int k = 0; k < int'(NB); k++)
        w[k] = x1[nc + wi*int'(NB) + k] ^ x2[nc + wi*int'(NB) + k];
      exp_q.push_back(w);
      exp_l_q.push_back(wi == len - 1);
    end
  endtask

  // Called at posedge+1; holds i_load for exactly one edge
  task automatic load(input logic [30:0] init, input logic [LW-1:0] len);
    i_load = 1'b1; i_init = init; i_len = len;
    @(posedge clk); #1;
    i_load = 1'b0;
  endtask

  // Collects handshaked words; optionally injects a load after inj_at handshakes
  task automatic capture(input int want, input bit rnd, input int inj_at,
                         input logic [30:0] inj_init, input logic [LW-1:0] inj_len,
                         input int budget);
    int k, inj_k;
    bit pv, pr, pl, injected;
    logic [NB-1:0] pw;
    k = 0; inj_k = 0; pv = 0; pr = 0; pl = 0; pw = '0; injected = 0;
    first_k = 0; inj_first_k = 0; stab_err = 0; hs_cnt = 0;
    obs_q.delete(); obs_l_q.delete();
    while (hs_cnt < want && k < budget) begin
      @(negedge clk);
      k++;
      if (o_valid && first_k == 0) first_k = k;
      if (injected && o_valid && inj_first_k == 0 && k > inj_k) inj_first_k = k - inj_k;
      if (pv && !pr && o_valid && (o_seq_bit !== pw || o_last !== pl)) stab_err++;
      if (o_valid && i_ready && !(i_load && i_len != '0)) begin
        obs_q.push_back(o_seq_bit);
        obs_l_q.push_back(o_last);
        hs_cnt++;
      end
      pv = o_valid; pr = i_ready; pw = o_seq_bit; pl = o_last;
      @(posedge clk); #1;
      i_load = 1'b0;
      if (!injected && inj_at >= 0 && hs_cnt == inj_at) begin
        i_load = 1'b1; i_init = inj_init; i_len = inj_len; i_ready = 1'b1;
        injected = 1; inj_k = k + 1;
      end else begin
        i_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
    timeout = (hs_cnt < want);
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({o_valid, o_last, o_busy, o_seq_bit} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut: got v=%b l=%b b=%b d=%h, expected all 0", o_valid, o_last, o_busy, o_seq_bit);
    end
    n_checks++;
    if ({v0, l0, b0, seq0} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut0: got v=%b l=%b b=%b d=%h, expected all 0", v0, l0, b0, seq0);
    end
  endtask

  task automatic test_nc0();
    logic [NB-1:0] ew[2];
    ew[0] = 8'h01; ew[1] = 8'h00;
    rdy0 = 1'b1; ld0 = 1'b1; init0 = '0; len0 = LW'(2);
    @(posedge clk); #1; ld0 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (v0 !== 1'b1 || seq0 !== ew[i] || l0 !== (i == 1)) begin
        n_fail++;
        $display("FAIL nc0_word%0d: got v=%b d=%h l=%b, expected v=1 d=%h l=%0d", i, v0, seq0, l0, ew[i], i == 1);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_checks++;
    if (v0 !== 1'b0 || b0 !== 1'b0) begin
      n_fail++;
      $display("FAIL nc0_idle: got v=%b b=%b, expected 0 0", v0, b0);
    end
  endtask

  task automatic test_stream(input bit rnd, input string nm);
    logic [NB-1:0] ew, ow;
    logic el, ol;
    @(posedge clk); #1;
    i_ready = 1'b1;
    push_model(31'h1234567, 40, NCD);
    load(31'h1234567, LW'(40));
    capture(40, rnd, -1, '0, '0, 3000);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL %s_timeout: got %0d handshakes, expected 40", nm, hs_cnt); end
    n_checks++;
    if (first_k != 201) begin n_fail++; $display("FAIL %s_latency: got %0d, expected 201", nm, first_k); end
    n_checks++;
    if (stab_err != 0) begin n_fail++; $display("FAIL %s_stable: got %0d changes under backpressure, expected 0", nm, stab_err); end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front(); el = exp_l_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL %s_word: got none, expected %h", nm, ew);
      end else begin
        ow = obs_q.pop_front(); ol = obs_l_q.pop_front();
        if (ow !== ew || ol !== el) begin
          n_fail++; $display("FAIL %s_word: got %h last=%b, expected %h last=%b", nm, ow, ol, ew, el);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_end: got v=%b b=%b, expected 0 0", nm, o_valid, o_busy);
    end
  endtask

  task automatic test_abort();
    logic [NB-1:0] ew, ow;
    logic el, ol;
    @(posedge clk); #1;
    i_ready = 1'b1;
    push_model(31'h1234567, 40, NCD);
    repeat (35) begin void'(exp_q.pop_back()); void'(exp_l_q.pop_back()); end
    push_model(31'h5A5A5, 10, NCD);
    load(31'h1234567, LW'(40));
    capture(15, 1'b0, 5, 31'h5A5A5, LW'(10), 3000);
    n_checks++;
    if (timeout) begin n_fail++; $display("FAIL abort_timeout: got %0d handshakes, expected 15", hs_cnt); end
    n_checks++;
    if (inj_first_k != 201) begin n_fail++; $display("FAIL abort_latency: got %0d, expected 201", inj_first_k); end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front(); el = exp_l_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL abort_word: got none, expected %h", ew);
      end else begin
        ow = obs_q.pop_front(); ol = obs_l_q.pop_front();
        if (ow !== ew || ol !== el) begin
          n_fail++; $display("FAIL abort_word: got %h last=%b, expected %h last=%b", ow, ol, ew, el);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_end: got busy=%b, expected 0", o_busy); end
  endtask

  task automatic test_rst(input bit mid_run, input string nm);
    logic [NB-1:0] ew, ow;
    logic el, ol;
    @(posedge clk); #1;
    i_ready = 1'b0;
    load(31'h0ABCDEF, LW'(40));
    repeat (mid_run ? 210 : 50) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (o_valid !== mid_run || o_busy !== 1'b1) begin
      n_fail++; $display("FAIL %s_pre: got v=%b b=%b, expected v=%b b=1", nm, o_valid, o_busy, mid_run);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({o_valid, o_last, o_busy, o_seq_bit} !== '0) begin
      n_fail++; $display("FAIL %s_async: got v=%b l=%b b=%b d=%h, expected all 0", nm, o_valid, o_last, o_busy, o_seq_bit);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    i_ready = 1'b1;
    push_model(31'h0ABCDEF, 40, NCD);
    load(31'h0ABCDEF, LW'(40));
    capture(40, 1'b0, -1, '0, '0, 3000);
    n_checks++;
    if (timeout || first_k != 201) begin
      n_fail++; $display("FAIL %s_reload: got latency %0d hs %0d, expected 201 and 40", nm, first_k, hs_cnt);
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front(); el = exp_l_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL %s_word: got none, expected %h", nm, ew);
      end else begin
        ow = obs_q.pop_front(); ol = obs_l_q.pop_front();
        if (ow !== ew || ol !== el) begin
          n_fail++; $display("FAIL %s_word: got %h last=%b, expected %h last=%b", nm, ow, ol, ew, el);
        end
      end
    end
  endtask

  task automatic test_len0();
    logic [NB-1:0] ew, ow;
    logic el, ol;
    @(posedge clk); #1;
    i_ready = 1'b1;
    load(31'h1111111, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
        n_fail++; $display("FAIL len0_idle: got b=%b v=%b, expected 0 0", o_busy, o_valid);
      end
      @(posedge clk); #1;
    end
    push_model(31'h1234567, 40, NCD);
    load(31'h1234567, LW'(40));
    capture(40, 1'b0, 10, 31'h7777777, '0, 3000);
    n_checks++;
    if (timeout || first_k != 201) begin
      n_fail++; $display("FAIL len0_run: got latency %0d hs %0d, expected 201 and 40", first_k, hs_cnt);
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front(); el = exp_l_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin
        n_fail++; $display("FAIL len0_word: got none, expected %h", ew);
      end else begin
        ow = obs_q.pop_front(); ol = obs_l_q.pop_front();
        if (ow !== ew || ol !== el) begin
          n_fail++; $display("FAIL len0_word: got %h last=%b, expected %h last=%b", ow, ol, ew, el);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; i_load = 1'b0; i_init = '0; i_len = '0; i_ready = 1'b0;
    ld0 = 1'b0; init0 = '0; len0 = '0; rdy0 = 1'b0;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_nc0();
    test_stream(1'b0, "stream");
    test_stream(1'b1, "bp");
    test_abort();
    test_rst(1'b0, "rst_wu");
    test_rst(1'b1, "rst_run");
    test_len0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
